// File: rtl/counter_timer_high_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : counter_timer_high_wb
//  Description : Upper 32-bit word of a chained 64-bit counter/timer with a
//                Wishbone register block (CONFIG / VALUE / DATA).
//                chain=1 : advances only on the low word's rollover strobe,
//                          reports its stop condition back to the low word and
//                          raises the combined 64-bit timeout interrupt.
//                chain=0 : standalone 32-bit counter/timer, counts every clock.
//  Ports       : wb_clk_i / wb_rst_i        clock, async active-high reset
//                wb_adr_i .. wb_stb_i        Wishbone slave request
//                wb_ack_o / wb_dat_o         registered Wishbone response
//                strobe_in                   low-word rollover strobe
//                is_offset_in                low word counts up to stop value 0
//                stop_in / enable_in         low-word stop flag and enable
//                stop_out                    high-word stop condition
//                enable_out                  local enable bit
//                irq                         one-cycle timeout interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_timer_high_wb #(
   parameter logic [31:0] BASE_ADR = 32'h2500_0000,
   parameter logic [7:0]  CONFIG   = 8'h00,
   parameter logic [7:0]  VALUE    = 8'h04,
   parameter logic [7:0]  DATA     = 8'h08
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   input  logic        strobe_in,
   input  logic        is_offset_in,
   input  logic        stop_in,
   input  logic        enable_in,
   output logic        stop_out,
   output logic        enable_out,
   output logic        irq
);

   localparam logic [31:0] ADR_CONFIG = BASE_ADR | {24'h00_0000, CONFIG};
   localparam logic [31:0] ADR_VALUE  = BASE_ADR | {24'h00_0000, VALUE};
   localparam logic [31:0] ADR_DATA   = BASE_ADR | {24'h00_0000, DATA};

   // ------------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------------
   logic        enable;
   logic        oneshot;
   logic        updown;       // 1 = count up, 0 = count down
   logic        chain;
   logic        irq_ena;
   logic [31:0] value_reset;
   logic [31:0] value_cur;
   logic        lastenable;
   logic        stop_in_d;    // previous stop_in, for the chained reload edge
   logic        timeout_d;    // previous timeout, for irq edge detection

   // ------------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------------
   logic        bus_req;
   logic        hit_config;
   logic        hit_value;
   logic        hit_data;
   logic        valid;
   logic        wr_config;
   logic        wr_value;
   logic        wr_data;
   logic [31:0] rd_data;

   // The !ack term stops a held strobe from being accepted twice.
   assign bus_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign hit_config = bus_req & (wb_adr_i == ADR_CONFIG);
   assign hit_value  = bus_req & (wb_adr_i == ADR_VALUE);
   assign hit_data   = bus_req & (wb_adr_i == ADR_DATA);
   assign valid      = hit_config | hit_value | hit_data;

   // CONFIG only has bits in the lowest byte, so only sel[0] matters there.
   assign wr_config  = hit_config & wb_we_i & wb_sel_i[0];
   assign wr_value   = hit_value  & wb_we_i;
   assign wr_data    = hit_data   & wb_we_i;

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  lanes
   );
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

   always_comb begin
      rd_data = 32'h0000_0000;
      if (hit_config)
         rd_data = {27'h000_0000, irq_ena, chain, updown, oneshot, enable};
      else if (hit_value)
         rd_data = value_reset;
      else if (hit_data)
         rd_data = value_cur;
   end

   // ------------------------------------------------------------------------
   // Counter datapath
   // ------------------------------------------------------------------------
   logic        loc_en;
   logic        tick;
   logic [31:0] tgt;
   logic [31:0] load_val;
   logic [31:0] step_val;
   logic [31:0] count_next;
   logic        stop_next;
   logic        chain_reload;
   logic        timeout;
   logic        irq_next;

   assign loc_en     = chain ? (enable & enable_in) : enable;
   assign enable_out = enable;
   assign tick       = chain ? strobe_in : 1'b1;

   // When the low word counts up to a stop value of 0 it rolls over one
   // strobe early, so the high word has to stop one count sooner.
   assign tgt      = updown ? (value_reset - {31'h0000_0000, (chain & is_offset_in)})
                            : 32'h0000_0000;
   assign load_val = updown ? 32'h0000_0000 : value_reset;
   assign step_val = updown ? (value_cur + 32'd1) : (value_cur - 32'd1);

   // Falling stop_in means the low word has just reloaded; follow it so both
   // words restart together.
   assign chain_reload = chain & ~oneshot & stop_in_d & ~stop_in;

   always_comb begin
      count_next = value_cur;
      if (wr_data) begin
         count_next = byte_merge(value_cur, wb_dat_i, wb_sel_i);
      end else if (loc_en) begin
         if (!lastenable) begin
            count_next = load_val;
         end else if (chain_reload) begin
            count_next = load_val;
         end else if (tick) begin
            // In chained mode the low word owns the stop/reload decision, so
            // a strobe at target still advances the high word.
            if ((value_cur != tgt) || chain)
               count_next = step_val;
            else if (!oneshot)
               count_next = load_val;
         end
      end
   end

   assign stop_next = loc_en & lastenable & (count_next == tgt);

   assign timeout  = chain ? (stop_out & stop_in) : stop_out;
   assign irq_next = irq_ena & loc_en & timeout & ~timeout_d & ~irq;

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0000_0000;
      end else begin
         wb_ack_o <= valid;
         if (valid) wb_dat_o <= rd_data;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         enable      <= 1'b0;
         oneshot     <= 1'b0;
         updown      <= 1'b0;
         chain       <= 1'b0;
         irq_ena     <= 1'b0;
         value_reset <= 32'h0000_0000;
      end else begin
         if (wr_config) begin
            enable  <= wb_dat_i[0];
            oneshot <= wb_dat_i[1];
            updown  <= wb_dat_i[2];
            chain   <= wb_dat_i[3];
            irq_ena <= wb_dat_i[4];
         end
         if (wr_value) value_reset <= byte_merge(value_reset, wb_dat_i, wb_sel_i);
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         value_cur  <= 32'h0000_0000;
         stop_out   <= 1'b0;
         lastenable <= 1'b0;
         stop_in_d  <= 1'b0;
         timeout_d  <= 1'b0;
         irq        <= 1'b0;
      end else begin
         value_cur  <= count_next;
         stop_out   <= stop_next;
         lastenable <= loc_en;
         stop_in_d  <= stop_in;
         timeout_d  <= timeout;
         irq        <= irq_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_timer_high_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_counter_timer_high_wb
//  Description : Directed self-checking bench for counter_timer_high_wb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_timer_high_wb;

   localparam logic [31:0] BASE   = 32'h2500_0000;
   localparam logic [31:0] A_CFG  = BASE | 32'h00;
   localparam logic [31:0] A_VAL  = BASE | 32'h04;
   localparam logic [31:0] A_DAT  = BASE | 32'h08;
   localparam logic [31:0] A_BAD  = BASE | 32'h0C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        ack;
   logic [31:0] rdat;
   logic        strobe_in = 1'b0;
   logic        is_offset_in = 1'b0;
   logic        stop_in = 1'b0;
   logic        enable_in = 1'b0;
   logic        stop_out;
   logic        enable_out;
   logic        irq;

   int total = 0;
   int bad   = 0;

   counter_timer_high_wb dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wb_adr_i     (adr),
      .wb_dat_i     (wdat),
      .wb_sel_i     (sel),
      .wb_we_i      (we),
      .wb_cyc_i     (cyc),
      .wb_stb_i     (stb),
      .wb_ack_o     (ack),
      .wb_dat_o     (rdat),
      .strobe_in    (strobe_in),
      .is_offset_in (is_offset_in),
      .stop_in      (stop_in),
      .enable_in    (enable_in),
      .stop_out     (stop_out),
      .enable_out   (enable_out),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bus transfer: returns the number of edges until ack (0 = no ack in 4).
   task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int edges);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
      edges = 0;
      for (int i = 1; i <= 4; i++) begin
         if (edges == 0) begin
            step();
            if (ack) edges = i;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step();
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d,
                          output int edges);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      edges = 0;
      d = '0;
      for (int i = 1; i <= 4; i++) begin
         if (edges == 0) begin
            step();
            if (ack) begin
               edges = i;
               d = rdat;
            end
         end
      end
      cyc = 1'b0; stb = 1'b0;
      step();
   endtask

   task automatic test_reset();
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
      total++; if (rdat !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h expected 0", rdat); end
      total++; if (stop_out !== 1'b0) begin bad++; $display("FAIL reset_stop: got %b expected 0", stop_out); end
      total++; if (enable_out !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b expected 0", enable_out); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
   endtask

   task automatic test_bus();
      int n;
      logic [31:0] d;
      wb_write(A_CFG, 32'h05, 4'hF, n);
      total++; if (n !== 1) begin bad++; $display("FAIL cfg_write_ack: got %0d edges expected 1", n); end
      total++; if (enable_out !== 1'b1) begin bad++; $display("FAIL cfg_enable_out: got %b expected 1", enable_out); end
      wb_read(A_CFG, d, n);
      total++; if (n !== 1) begin bad++; $display("FAIL cfg_read_ack: got %0d edges expected 1", n); end
      total++; if (d !== 32'h05) begin bad++; $display("FAIL cfg_readback: got %h expected 00000005", d); end
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle: got %b expected 0", ack); end
      wb_read(A_BAD, d, n);
      total++; if (n !== 0) begin bad++; $display("FAIL unmapped_ack: got %0d edges expected 0 (no ack)", n); end
      wb_write(A_CFG, 32'h00, 4'hF, n);
   endtask

   task automatic test_down_count();
      int n;
      bit exp_stop [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
      bit exp_ack  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
      logic [31:0] exp_dat [8] = '{32'd3, 32'd0, 32'd1, 32'd0, 32'd3, 32'd0, 32'd1, 32'd0};
      wb_write(A_VAL, 32'd3, 4'hF, n);
      wb_write(A_CFG, 32'h01, 4'hF, n);
      total++; if (stop_out !== 1'b0) begin bad++; $display("FAIL down_start_stop: got %b expected 0", stop_out); end
      // Hold a DATA read request: the slave answers every second cycle.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DAT; sel = 4'hF;
      for (int i = 0; i < 8; i++) begin
         step();
         total++; if (stop_out !== exp_stop[i]) begin bad++; $display("FAIL down_stop[%0d]: got %b expected %b", i, stop_out, exp_stop[i]); end
         total++; if (ack !== exp_ack[i]) begin bad++; $display("FAIL down_ack[%0d]: got %b expected %b", i, ack, exp_ack[i]); end
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL down_irq[%0d]: got %b expected 0", i, irq); end
         if (exp_ack[i]) begin
            total++; if (rdat !== exp_dat[i]) begin bad++; $display("FAIL down_data[%0d]: got %h expected %h", i, rdat, exp_dat[i]); end
         end
      end
      cyc = 1'b0; stb = 1'b0;
      step();
      wb_write(A_CFG, 32'h00, 4'hF, n);
   endtask

   task automatic test_up_oneshot_irq();
      int n;
      logic [31:0] d;
      bit exp_stop [6] = '{0, 1, 1, 1, 1, 1};
      bit exp_irq  [6] = '{0, 0, 1, 0, 0, 0};
      wb_write(A_VAL, 32'd2, 4'hF, n);
      wb_write(A_CFG, 32'h17, 4'hF, n);
      for (int i = 0; i < 6; i++) begin
         step();
         total++; if (stop_out !== exp_stop[i]) begin bad++; $display("FAIL oneshot_stop[%0d]: got %b expected %b", i, stop_out, exp_stop[i]); end
         total++; if (irq !== exp_irq[i]) begin bad++; $display("FAIL oneshot_irq[%0d]: got %b expected %b", i, irq, exp_irq[i]); end
      end
      wb_read(A_DAT, d, n);
      total++; if (d !== 32'd2) begin bad++; $display("FAIL oneshot_hold: got %h expected 00000002", d); end
      wb_write(A_CFG, 32'h00, 4'hF, n);
   endtask

   task automatic test_chained_up();
      int n;
      logic [31:0] d;
      logic exp;
      is_offset_in = 1'b1; enable_in = 1'b1; stop_in = 1'b0; strobe_in = 1'b0;
      wb_write(A_VAL, 32'd5, 4'hF, n);
      wb_write(A_CFG, 32'h0D, 4'hF, n);
      for (int j = 0; j < 18; j++) begin
         strobe_in = ((j % 4) == 3);
         step();
         exp = (((j + 1) / 4) == 4);
         total++; if (stop_out !== exp) begin bad++; $display("FAIL chain_stop[%0d]: got %b expected %b", j, stop_out, exp); end
      end
      strobe_in = 1'b0;
      wb_read(A_DAT, d, n);
      total++; if (d !== 32'd4) begin bad++; $display("FAIL chain_count: got %h expected 00000004", d); end
   endtask

   task automatic test_chained_irq();
      int n;
      logic [31:0] d;
      wb_write(A_CFG, 32'h1D, 4'hF, n);
      total++; if (stop_out !== 1'b1) begin bad++; $display("FAIL chirq_stop_held: got %b expected 1", stop_out); end
      stop_in = 1'b1;
      step();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL chirq_pulse: got %b expected 1", irq); end
      step();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL chirq_single: got %b expected 0", irq); end
      stop_in = 1'b0;
      step();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL chirq_after: got %b expected 0", irq); end
      total++; if (stop_out !== 1'b0) begin bad++; $display("FAIL chirq_reload_stop: got %b expected 0", stop_out); end
      wb_read(A_DAT, d, n);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL chirq_reload_value: got %h expected 00000000", d); end
      wb_write(A_CFG, 32'h00, 4'hF, n);
      is_offset_in = 1'b0; enable_in = 1'b0;
   endtask

   task automatic test_async_reset();
      int n;
      logic [31:0] d;
      wb_write(A_CFG, 32'h05, 4'hF, n);
      wb_write(A_DAT, 32'h1234, 4'hF, n);
      wb_read(A_DAT, d, n);
      total++; if (d !== 32'h1235) begin bad++; $display("FAIL pre_reset_count: got %h expected 00001235", d); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (rdat !== 32'h0) begin bad++; $display("FAIL async_dat: got %h expected 0", rdat); end
      total++; if (enable_out !== 1'b0) begin bad++; $display("FAIL async_enable: got %b expected 0", enable_out); end
      total++; if (stop_out !== 1'b0) begin bad++; $display("FAIL async_stop: got %b expected 0", stop_out); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq: got %b expected 0", irq); end
      step();
      rst = 1'b0;
      step();
      wb_read(A_DAT, d, n);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_data: got %h expected 0", d); end
      wb_read(A_VAL, d, n);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_value: got %h expected 0", d); end
      wb_read(A_CFG, d, n);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL post_reset_config: got %h expected 0", d); end
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      step();
      test_bus();
      test_down_count();
      test_up_oneshot_irq();
      test_chained_up();
      test_chained_irq();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
